prf_freelist: RTL

- Physical register free list feeding the rename stage; supplies up to two free physical register indices per cycle.
- Rename uses those indices as destination pregs and marks them busy in the register status table. Commit returns superseded pregs.
- Speculative allocations are rolled back on flush by restoring the read pointer to a commit-tracked pointer.
- Preg 0 is the hardwired-zero register; it is never allocated and never enters the list.

---
 rtl/prf_freelist.sv | 129 ++++++++++++
 1 files changed

// File: rtl/prf_freelist.sv
// Physical register free list for the rename stage.
// Circular buffer of free preg indices: up to two allocations per cycle from
// the head, up to two returns per cycle at the tail. A commit-tracked head
// lets a flush roll back every uncommitted allocation in one cycle.
module prf_freelist #(
   parameter int PREGS = 64,
   parameter int AREGS = 32
) (
   input  logic                              clk_i,
   input  logic                              rst_ni,
   input  logic                              alloc_req0_i,
   input  logic                              alloc_req1_i,
   output logic                              alloc_rdy_o,
   output logic [$clog2(PREGS)-1:0]          alloc_preg0_o,
   output logic [$clog2(PREGS)-1:0]          alloc_preg1_o,
   input  logic                              commit_pop0_i,
   input  logic                              commit_pop1_i,
   input  logic                              free0_vld_i,
   input  logic [$clog2(PREGS)-1:0]          free0_preg_i,
   input  logic                              free1_vld_i,
   input  logic [$clog2(PREGS)-1:0]          free1_preg_i,
   input  logic                              flush_i,
   output logic [$clog2(PREGS-AREGS):0]      free_cnt_o
);

   localparam int PW    = $clog2(PREGS);   // preg index width
   localparam int DEPTH = PREGS - AREGS;   // list capacity
   localparam int IW    = $clog2(DEPTH);   // buffer index width
   localparam int CW    = IW + 1;          // pointer width: index plus wrap bit

   typedef logic [CW-1:0] ptr_t;
   typedef logic [PW-1:0] preg_t;

   preg_t         mem_q [DEPTH];
   ptr_t          head_q, commit_head_q, tail_q, free_cnt_q;
   ptr_t          head_d, commit_head_d, tail_d, free_cnt_d, head_adv;
   logic [1:0]    n_req, n_push, n_commit;
   logic          push0, push1, do_pop;
   logic [IW-1:0] head_p1, wr_idx0, wr_idx1;
   logic          dup_in_list;

   // Request decode, ready and read ports. Ready looks only at the registered
   // count, so same-cycle frees never feed an allocation.
   assign n_req         = {1'b0, alloc_req0_i} + {1'b0, alloc_req1_i};
   assign alloc_rdy_o   = !flush_i && (free_cnt_q >= ptr_t'(n_req));
   assign do_pop        = alloc_rdy_o && (n_req != 2'd0);
   assign head_p1       = head_q[IW-1:0] + IW'(1);
   assign alloc_preg0_o = mem_q[head_q[IW-1:0]];
   // Slot 1 takes the head entry when slot 0 is not asking for one.
   assign alloc_preg1_o = alloc_req0_i ? mem_q[head_p1] : mem_q[head_q[IW-1:0]];
   assign free_cnt_o    = free_cnt_q;

   // Returns of preg 0 are dropped; port 1 lands just behind port 0.
   assign push0    = free0_vld_i && (free0_preg_i != '0);
   assign push1    = free1_vld_i && (free1_preg_i != '0);
   assign n_push   = {1'b0, push0} + {1'b0, push1};
   assign wr_idx0  = tail_q[IW-1:0];
   assign wr_idx1  = tail_q[IW-1:0] + IW'(push0);
   assign n_commit = {1'b0, commit_pop0_i} + {1'b0, commit_pop1_i};

   // Next-state pointers: commit always advances, flush snaps head back to
   // the updated commit head, otherwise head advances by the granted count.
   always_comb begin
      commit_head_d = commit_head_q + ptr_t'(n_commit);
      head_adv      = do_pop ? head_q + ptr_t'(n_req) : head_q;
      head_d        = flush_i ? commit_head_d : head_adv;
      tail_d        = tail_q + ptr_t'(n_push);
      free_cnt_d    = tail_d - head_d;
   end

   // Pointer and count registers; reset leaves the list full.
   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values, independent of block ordering.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         head_q        <= '0;
         commit_head_q <= '0;
         tail_q        <= ptr_t'(DEPTH);
         free_cnt_q    <= ptr_t'(DEPTH);
      end else begin
         head_q        <= head_d;
         commit_head_q <= commit_head_d;
         tail_q        <= tail_d;
         free_cnt_q    <= free_cnt_d;
      end
   end

   // Free-list storage, written at the tail by the return ports.
   // NOTE: this array is deliberately reset -- its reset image is the initial
   // set of free pregs (AREGS..PREGS-1), not don't-care data.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= preg_t'(AREGS + i);
         end
      end else begin
         if (push0) mem_q[wr_idx0] <= free0_preg_i;
         if (push1) mem_q[wr_idx1] <= free1_preg_i;
      end
   end

   // Detect a returned preg that is already on the list, or two identical
   // returns in one cycle. Feeds the duplicate assertion only.
   always_comb begin
      logic [IW-1:0] offs;
      // NOTE: every variable gets a default before any conditional write,
      // otherwise the untaken paths would infer a latch.
      dup_in_list = 1'b0;
      offs        = '0;
      for (int i = 0; i < DEPTH; i++) begin
         offs = IW'(i) - head_q[IW-1:0];
         if (({1'b0, offs} < free_cnt_q) &&
             ((push0 && (mem_q[i] == free0_preg_i)) ||
              (push1 && (mem_q[i] == free1_preg_i)))) begin
            dup_in_list = 1'b1;
         end
      end
      if (push0 && push1 && (free0_preg_i == free1_preg_i)) dup_in_list = 1'b1;
   end

   // Illegal-use checks.
   a_no_overflow: assert property (@(posedge clk_i) disable iff (!rst_ni)
      free_cnt_d <= ptr_t'(DEPTH));
   a_commit_behind_head: assert property (@(posedge clk_i) disable iff (!rst_ni)
      ptr_t'(n_commit) <= ptr_t'(head_adv - commit_head_q));
   a_no_duplicate: assert property (@(posedge clk_i) disable iff (!rst_ni)
      !dup_in_list);

endmodule
